uart_rx_deserializer: RTL

- Receive-side DUT driven by the UART interface's `rx` and `rx_enable` signals. Consumes the serial line and produces parallel bytes.
- Samples each bit at its centre; frame format is start, DATA_BITS data bits sent LSB-first, optional parity, one stop bit.
- Delivers each good byte through a one-entry valid/ready holding register to the downstream register/FIFO logic.
- Flags framing, parity and overrun errors as single-cycle pulses.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx_deserializer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types, defaults and the parity helper used by the RX path
// (and later by the TX loopback logic).
package uart_pkg;

  localparam int UART_CLKS_PER_BIT  = 16;
  localparam int UART_DATA_BITS     = 8;
  localparam int UART_MAX_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_e;

  // Expected parity bit for a data word; zero-extension does not change the XOR.
  function automatic logic uart_parity(input logic [UART_MAX_DATA_BITS-1:0] data,
                                       input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous input; resets to a programmable
// value so an idle-high serial line does not look like a start edge.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: centre-samples start/data/parity/stop bits and hands good
// bytes to a one-entry holding register; errors are single-cycle pulses.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rx_enable,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             PAR_ODD  = (PARITY_ODD != 0);

  uart_rx_state_e       state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bad_q;
  logic                 rx_s;
  logic                 rx_s_prev;
  logic                 bit_done;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  assign bit_done = (cnt_q == CNT_LAST);
  assign busy     = (state_q != IDLE);

  // Handshake: rx_valid=1 means rx_data holds a byte; it is consumed on any
  // cycle with rx_valid & rx_ready, and rx_data is frozen until then. A new
  // good frame may load in the same cycle the old byte is consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_bad_q  <= 1'b0;
      rx_s_prev  <= 1'b1;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_s_prev  <= rx_s;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (state_q != IDLE && !rx_enable) begin
        // Abort silently; any held byte survives.
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rx_enable && rx_s_prev && !rx_s) begin
              state_q   <= START;
              cnt_q     <= '0;
              par_bad_q <= 1'b0;
            end
          end
          START: begin
            if (cnt_q == CNT_HALF) begin
              cnt_q   <= '0;
              idx_q   <= '0;
              state_q <= rx_s ? IDLE : DATA;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          DATA: begin
            if (bit_done) begin
              cnt_q   <= '0;
              shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
              if (idx_q == IDX_LAST) state_q <= (PARITY_EN != 0) ? PARITY : STOP;
              else                   idx_q   <= idx_q + 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          PARITY: begin
            if (bit_done) begin
              cnt_q     <= '0;
              par_bad_q <= (rx_s != uart_parity(UART_MAX_DATA_BITS'(shift_q), PAR_ODD));
              state_q   <= STOP;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          STOP: begin
            if (bit_done) begin
              cnt_q   <= '0;
              state_q <= IDLE;
              if (!rx_s)                     frame_err  <= 1'b1;
              else if (par_bad_q)            parity_err <= 1'b1;
              else if (!rx_valid || rx_ready) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
              end else                       overrun    <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
